max_pooling: RTL and testbench
==============================

MAX_POOLING -- requirements
Module: max_pooling

Interface
- REQ-001: Parameter `size`, default 4'd8, is the pooled-map edge length; the input map is 2*size x 2*size.
- REQ-002: `clk`  input  1  sole clock; all state changes on the rising edge.
- REQ-003: `reset_n`  input  1  reset, synchronous, active-low.
- REQ-004: `pool_start`  input  1  operation enable; held high for the whole operation; low returns the block to IDLE.
- REQ-005: `input_value`  input  16  signed feature-map sample, streamed row-major, one per cycle during LOAD.
- REQ-006: `pooled_value`  output  16  signed maximum of one 2x2 window (reg).
- REQ-007: `history_value`  output  3  argmax position within the window, for consumption by the unpooling stage (reg).
- REQ-008: `out_valid`  output  1  high in each cycle in which `pooled_value` and `history_value` carry a new result (reg).
- REQ-009: `pool_end`  output  1  set when all windows are computed; held until IDLE (reg).
- REQ-010: `out_end`  output  1  set after the last result is emitted; held until IDLE (reg).

Function
- REQ-011: The block SHALL implement the FSM IDLE -> ARM -> LOAD -> POOL -> OUT -> DONE.
- REQ-012: IDLE: `pool_start` low; all counters cleared; `out_valid`, `pool_end` and `out_end` low.
- REQ-013: First edge with `pool_start` high moves IDLE to ARM; no sample is captured in ARM.
- REQ-014: ARM moves to LOAD on the next edge; LOAD captures `input_value` on each of the next 4*size*size edges into in[r][c], with c incrementing and wrapping at 2*size-1 into r+1.
- REQ-015: After capture of in[2*size-1][2*size-1], the FSM moves to POOL.
- REQ-016: POOL processes one window (i,j) per cycle, row-major, for size*size cycles; window (i,j) = in[2i][2j], in[2i][2j+1], in[2i+1][2j], in[2i+1][2j+1], with positions 0,1,2,3 in that order.
- REQ-017: Comparison SHALL be signed 16-bit; the stored maximum is the window value, and the stored history is its position index 0..3.
- REQ-018: Tie rule: a later position replaces the current maximum only when strictly greater, so ties keep the lowest index.
- REQ-019: Encoding invariant: history = 2*row_offset + col_offset; values 4..7 are never produced.
- REQ-020: `pool_end` SHALL rise on the edge that stores window (size-1,size-1); the FSM then enters OUT.
- REQ-021: OUT presents result (i,j) row-major, one per cycle, for size*size cycles, with `out_valid` high on exactly those cycles.
- REQ-022: After the last result the FSM enters DONE: `out_valid` low; `out_end` rises on the next edge and holds.
- REQ-023: `pooled_value` and `history_value` SHALL hold their last values outside OUT.
- REQ-024: Latency from the first LOAD capture edge to the first `out_valid` SHALL be 4*size*size + size*size cycles.
- REQ-025: DONE is held while `pool_start` stays high; there is no restart without a low cycle.
- REQ-026: `pool_start` low in any state returns the FSM to IDLE on the next edge and clears `out_valid`, `pool_end` and `out_end`; data arrays are not cleared.
- REQ-027: After an abort, a new operation fully overwrites the array before any window is computed; stale data SHALL never appear at the output.
- REQ-028: Counter widths SHALL hold 2*size without overflow for any size <= 8.

Reset
- REQ-029: `reset_n` low at a rising edge forces IDLE and clears all counters.
- REQ-030: The same reset clears `pooled_value`, `history_value`, `out_valid`, `pool_end` and `out_end` to 0.
- REQ-031: Reset SHALL take priority over `pool_start`, including mid-operation.
- REQ-032: Array contents after reset are don't-care.

Verification (size=2, 4x4 input)
- REQ-033: Input 0..15 row-major -> outputs (5,3),(7,3),(13,3),(15,3) on 4 consecutive `out_valid` cycles, 20 cycles after the first capture; `out_end` follows.
- REQ-034: All 16 samples = 16'sd7 -> every `pooled_value`=7 and `history_value`=0 (tie rule).
- REQ-035: Window 0 = {-5,-3,-8,-1}, others 16'h8000 -> result 0 = (-1,3); results 1..3 = (-32768,0).
- REQ-036: Window 0 = {1,9,4,2} -> (9,1); {1,2,9,4} -> (9,2); {9,1,2,3} -> (9,0).
- REQ-037: Drop `pool_start` after 6 captures, then rerun with 0..15 -> all flags low on the following edge, and the rerun output matches REQ-033.
- REQ-038: Assert `reset_n` low during OUT -> all outputs 0 at the next edge; no further `out_valid` until a new start.

Source files
------------

// File: rtl/max_pooling.sv
// 2x2 max pooling with argmax history.
//
// Captures a (2*size x 2*size) signed 16-bit feature map streamed row-major,
// reduces every non-overlapping 2x2 window to its maximum and the position
// (0..3) of that maximum, then streams the size*size results out row-major.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        synchronous active-low reset
//   pool_start     operation enable, held high for the whole operation
//   input_value    signed sample, one per cycle while loading
//   pooled_value   signed window maximum (registered, holds outside OUT)
//   history_value  argmax position: 2*row_offset + col_offset (registered)
//   out_valid      high on each cycle carrying a new result
//   pool_end       all windows computed; held until IDLE
//   out_end        last result emitted; held until IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for pool_start; counters and flags cleared
// ARM   | one dead cycle before capture begins
// LOAD  | capture 4*size*size samples into the input map
// POOL  | reduce one 2x2 window per cycle into the result buffer
// OUT   | present one result per cycle with out_valid
// DONE  | out_end set; wait for pool_start to drop

module max_pooling #(
  parameter logic [3:0] size = 4'd8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pool_start,
  input  logic signed [15:0] input_value,
  output logic signed [15:0] pooled_value,
  output logic [2:0]         history_value,
  output logic               out_valid,
  output logic               pool_end,
  output logic               out_end
);

  localparam int SZ   = int'(size);
  localparam int EDGE = 2 * SZ;
  localparam int NWIN = SZ * SZ;
  // Counters must be able to hold EDGE itself (the row counter reaches it
  // after the final capture).
  localparam int CW   = $clog2(EDGE + 1);
  localparam int AW   = (EDGE > 1) ? $clog2(EDGE) : 1;
  localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
    S_POOL,
    S_OUT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] load_r_q, load_c_q;
  logic [CW-1:0] win_i_q, win_j_q;
  logic [KW-1:0] win_k_q;

  logic signed [15:0] in_q      [EDGE][EDGE];
  logic signed [15:0] res_val_q [NWIN];
  logic [2:0]         res_hist_q[NWIN];

  logic load_last;
  logic win_last;

  logic [AW-1:0]      r0, r1, c0, c1;
  logic signed [15:0] win_vals [4];
  logic signed [15:0] win_max;
  logic [2:0]         win_pos;

  assign load_last = (load_r_q == CW'(EDGE - 1)) && (load_c_q == CW'(EDGE - 1));
  assign win_last  = (win_k_q == KW'(NWIN - 1));

  // Next-state logic. Dropping pool_start from any state aborts to IDLE.
  always_comb begin
    state_d = state_q;
    if (!pool_start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARM;
        S_ARM:   state_d = S_LOAD;
        S_LOAD:  if (load_last) state_d = S_POOL;
        S_POOL:  if (win_last)  state_d = S_OUT;
        S_OUT:   if (win_last)  state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Window reduction. Positions are scanned 0..3 and only a strictly greater
  // value replaces the running maximum, so ties resolve to the lowest index.
  always_comb begin
    r0 = AW'({win_i_q, 1'b0});
    c0 = AW'({win_j_q, 1'b0});
    r1 = r0 | AW'(1);
    c1 = c0 | AW'(1);
    win_vals[0] = in_q[r0][c0];
    win_vals[1] = in_q[r0][c1];
    win_vals[2] = in_q[r1][c0];
    win_vals[3] = in_q[r1][c1];
    win_max = win_vals[0];
    win_pos = 3'd0;
    for (int p = 1; p < 4; p++) begin
      if (win_vals[p] > win_max) begin
        win_max = win_vals[p];
        win_pos = 3'(p);
      end
    end
  end

  // Control state, counters and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      load_r_q      <= '0;
      load_c_q      <= '0;
      win_i_q       <= '0;
      win_j_q       <= '0;
      win_k_q       <= '0;
      pooled_value  <= '0;
      history_value <= '0;
      out_valid     <= 1'b0;
      pool_end      <= 1'b0;
      out_end       <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      if (state_d == S_IDLE) begin
        load_r_q <= '0;
        load_c_q <= '0;
        win_i_q  <= '0;
        win_j_q  <= '0;
        win_k_q  <= '0;
        pool_end <= 1'b0;
        out_end  <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_c_q == CW'(EDGE - 1)) begin
              load_c_q <= '0;
              load_r_q <= load_r_q + 1'b1;
            end else begin
              load_c_q <= load_c_q + 1'b1;
            end
          end
          S_POOL: begin
            if (win_last) begin
              win_i_q  <= '0;
              win_j_q  <= '0;
              win_k_q  <= '0;
              pool_end <= 1'b1;
            end else begin
              win_k_q <= win_k_q + 1'b1;
              if (win_j_q == CW'(SZ - 1)) begin
                win_j_q <= '0;
                win_i_q <= win_i_q + 1'b1;
              end else begin
                win_j_q <= win_j_q + 1'b1;
              end
            end
          end
          S_OUT: begin
            pooled_value  <= res_val_q[win_k_q];
            history_value <= res_hist_q[win_k_q];
            out_valid     <= 1'b1;
            if (win_last) win_k_q <= '0;
            else          win_k_q <= win_k_q + 1'b1;
          end
          S_DONE: out_end <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Data storage needs no reset: every operation rewrites the whole map in
  // LOAD before POOL reads it, and every result before OUT presents it.
  always_ff @(posedge clk) begin
    if (reset_n && pool_start) begin
      if (state_q == S_LOAD)
        in_q[load_r_q[AW-1:0]][load_c_q[AW-1:0]] <= input_value;
      if (state_q == S_POOL) begin
        res_val_q[win_k_q]  <= win_max;
        res_hist_q[win_k_q] <= win_pos;
      end
    end
  end

endmodule

// File: tb/tb_max_pooling.sv
module tb_max_pooling;

  localparam int S     = 2;
  localparam int E     = 2 * S;
  localparam int NCAP  = E * E;
  localparam int NW    = S * S;
  // Schedule in consecutive pool_start-high edges since the start edge.
  localparam int CAP0  = 3;
  localparam int CAPN  = 2 + NCAP;
  localparam int PEND  = 2 + NCAP + NW;
  localparam int OV0   = 3 + NCAP + NW;
  localparam int OVN   = 2 + NCAP + 2 * NW;
  localparam int OEND  = 3 + NCAP + 2 * NW;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pool_start;
  logic signed [15:0] input_value;
  logic signed [15:0] pooled_value;
  logic [2:0]         history_value;
  logic               out_valid;
  logic               pool_end;
  logic               out_end;

  max_pooling #(.size(4'd2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pool_start    (pool_start),
    .input_value   (input_value),
    .pooled_value  (pooled_value),
    .history_value (history_value),
    .out_valid     (out_valid),
    .pool_end      (pool_end),
    .out_end       (out_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic signed [15:0] img [E][E];
  logic signed [15:0] res_v [NW];
  logic [2:0]         res_h [NW];
  int                 n_edge = 0;
  logic               chk_en = 1'b0;
  logic signed [15:0] m_pv = '0;
  logic [2:0]         m_hv = '0;
  logic               m_ov = 1'b0, m_pe = 1'b0, m_oe = 1'b0;

  function automatic void compute_windows();
    for (int wi = 0; wi < S; wi++) begin
      for (int wj = 0; wj < S; wj++) begin
        int best_p = 0;
        logic signed [15:0] best = img[2*wi][2*wj];
        for (int p = 1; p < 4; p++) begin
          if (img[2*wi + p/2][2*wj + p%2] > best) begin
            best   = img[2*wi + p/2][2*wj + p%2];
            best_p = p;
          end
        end
        res_v[wi*S + wj] = best;
        res_h[wi*S + wj] = 3'(best_p);
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        n_edge = 0;
        m_pv = '0; m_hv = '0;
        m_ov = 1'b0; m_pe = 1'b0; m_oe = 1'b0;
        chk_en = 1'b1;
      end else if (!pool_start) begin
        n_edge = 0;
        m_ov = 1'b0; m_pe = 1'b0; m_oe = 1'b0;
      end else begin
        n_edge++;
        if (n_edge >= CAP0 && n_edge <= CAPN)
          img[(n_edge - CAP0) / E][(n_edge - CAP0) % E] = input_value;
        if (n_edge == CAPN) compute_windows();
        m_ov = (n_edge >= OV0 && n_edge <= OVN);
        if (m_ov) begin
          m_pv = res_v[n_edge - OV0];
          m_hv = res_h[n_edge - OV0];
        end
        m_pe = (n_edge >= PEND);
        m_oe = (n_edge >= OEND);
      end
    end
  end

  // ---------------- compare process ----------------
  logic signed [15:0] obs_v[$];
  logic [2:0]         obs_h[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid",     32'(out_valid),     32'(m_ov));
        chk("pool_end",      32'(pool_end),      32'(m_pe));
        chk("out_end",       32'(out_end),       32'(m_oe));
        chk("pooled_value",  pooled_value,       m_pv);
        chk("history_value", 32'(history_value), 32'(m_hv));
        if (out_valid === 1'b1) begin
          obs_v.push_back(pooled_value);
          obs_h.push_back(history_value);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic signed [15:0] stim [NCAP];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: full run; 1: abort after 6 captures; 2: reset during OUT
  task automatic run(input int mode);
    obs_v.delete();
    obs_h.delete();
    pool_start = 1'b1;
    step();
    step();
    for (int k = 0; k < NCAP; k++) begin
      if (mode == 1 && k == 6) begin
        pool_start  = 1'b0;
        input_value = 16'sd0;
        step();
        step();
        chk("abort_no_results", obs_v.size(), 0);
        return;
      end
      input_value = stim[k];
      step();
    end
    input_value = 16'($urandom);
    if (mode == 2) begin
      repeat (OV0 - CAPN + 1) step();
      reset_n    = 1'b0;
      pool_start = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (8) step();
      chk("reset_mid_out_count", obs_v.size(), 2);
    end else begin
      repeat (OEND - CAPN + 3) step();
      pool_start = 1'b0;
      repeat (2) step();
      chk("result_count", obs_v.size(), NW);
    end
  endtask

  task automatic expect_res(input string name, input int idx, input int v, input int h);
    chk({name, "_model_val"},  res_v[idx],      v);
    chk({name, "_model_hist"}, 32'(res_h[idx]), h);
    if (idx < obs_v.size()) begin
      chk({name, "_val"},  obs_v[idx],      v);
      chk({name, "_hist"}, 32'(obs_h[idx]), h);
    end else begin
      chk({name, "_present"}, obs_v.size(), idx + 1);
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < NCAP; k++) stim[k] = 16'(k);
  endtask

  task automatic fill_const(input logic signed [15:0] v);
    for (int k = 0; k < NCAP; k++) stim[k] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    pool_start  = 1'b0;
    input_value = 16'sd0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // ramp 0..15
    fill_ramp();
    run(0);
    expect_res("ramp_r0", 0, 5, 3);
    expect_res("ramp_r1", 1, 7, 3);
    expect_res("ramp_r2", 2, 13, 3);
    expect_res("ramp_r3", 3, 15, 3);

    // all equal -> lowest index wins
    fill_const(16'sd7);
    run(0);
    for (int r = 0; r < NW; r++) expect_res("ties", r, 7, 0);

    // negative window against most-negative background
    fill_const(16'sh8000);
    stim[0] = -16'sd5; stim[1] = -16'sd3; stim[4] = -16'sd8; stim[5] = -16'sd1;
    run(0);
    expect_res("neg_r0", 0, -1, 3);
    for (int r = 1; r < NW; r++) expect_res("neg_rest", r, -32768, 0);

    fill_const(16'sd0);
    stim[0] = 16'sd1; stim[1] = 16'sd9; stim[4] = 16'sd4; stim[5] = 16'sd2;
    run(0);
    expect_res("pos1", 0, 9, 1);

    stim[0] = 16'sd1; stim[1] = 16'sd2; stim[4] = 16'sd9; stim[5] = 16'sd4;
    run(0);
    expect_res("pos2", 0, 9, 2);

    stim[0] = 16'sd9; stim[1] = 16'sd1; stim[4] = 16'sd2; stim[5] = 16'sd3;
    run(0);
    expect_res("pos0", 0, 9, 0);

    // abort then rerun: stale samples must not leak
    for (int k = 0; k < NCAP; k++) stim[k] = 16'sh7fff;
    run(1);
    fill_ramp();
    run(0);
    expect_res("rerun_r0", 0, 5, 3);
    expect_res("rerun_r3", 3, 15, 3);

    // reset during OUT
    fill_ramp();
    run(2);
    expect_res("pre_reset_r0", 0, 5, 3);
    expect_res("pre_reset_r1", 1, 7, 3);

    // randomized runs, checked cycle-by-cycle against the model
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NCAP; k++) begin
        if (t % 2 == 0) stim[k] = 16'($urandom);
        else            stim[k] = 16'($urandom_range(0, 6)) - 16'sd3;
      end
      run(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
